// File: rtl/color_mixer_pkg.sv
// Shared constants, derivations and the power-on priority rule for the colour mixer.
package color_mixer_pkg;

   // RGB555 field placement inside a palette word ({B,G,R}, bit 15 unused)
   localparam int unsigned CH_W  = 5;
   localparam int unsigned R_LSB = 0;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_LSB = 10;

   typedef enum logic [1:0] {
      CPU_IDLE,
      CPU_PEND,
      CPU_RDWT,
      CPU_DONE
   } cpu_state_t;

   function automatic int unsigned sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned pal_aw(input int unsigned idx_w, input int unsigned bank_w);
      return idx_w + bank_w;
   endfunction

   // Lowest opaque layer wins; nothing opaque falls back to the last layer.
   function automatic int unsigned default_sel(input int unsigned layer_n, input int unsigned n);
      int unsigned sel;
      sel = n - 1;
      for (int unsigned k = n; k > 0; k--)
         if (((layer_n >> (k - 1)) & 1) == 0) sel = k - 1;
      return sel;
   endfunction

endpackage

// File: rtl/color_mixer_gen_if.sv
// Layer/video and CPU bus bundle of the colour mixer.
interface color_mixer_gen_if #(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned OBP_W      = 2,
   parameter int unsigned BANK_W     = 1
);
   import color_mixer_pkg::*;

   localparam int unsigned PAL_AW = pal_aw(IDX_W, BANK_W);

   logic                        NCBLK;
   logic [NUM_LAYERS-1:0]       LAYER_N;
   logic [NUM_LAYERS*IDX_W-1:0] LAYER_IDX;
   logic [OBP_W-1:0]            OBP;
   logic [PAL_AW:0]             ADDR;
   logic [7:0]                  DIN;
   logic [7:0]                  DOUT;
   logic                        NRD;
   logic                        NWR;
   logic                        CRAMCS;
   logic                        PRAMCS;
   logic                        NWAIT;
   logic [CH_W-1:0]             R;
   logic [CH_W-1:0]             G;
   logic [CH_W-1:0]             B;
   logic                        BLK_OUT;

   modport slave (
      input  NCBLK, LAYER_N, LAYER_IDX, OBP, ADDR, DIN, NRD, NWR, CRAMCS, PRAMCS,
      output DOUT, NWAIT, R, G, B, BLK_OUT
   );

   modport master (
      output NCBLK, LAYER_N, LAYER_IDX, OBP, ADDR, DIN, NRD, NWR, CRAMCS, PRAMCS,
      input  DOUT, NWAIT, R, G, B, BLK_OUT
   );

endinterface

// File: rtl/color_pal_ram.sv
// Single-port palette RAM, synchronous read (old data on write), two byte enables.
module color_pal_ram #(
   parameter int unsigned AW = 9
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [1:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [15:0]   wdata_i,
   output logic [15:0]   rdata_o
);

   logic [15:0] mem_q [1 << AW];

   // read every cycle, write only the enabled byte lanes
   always_ff @(posedge clk_i) begin
      rdata_o <= mem_q[addr_i];
      if (we_i && be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
   end

endmodule

// File: rtl/color_mixer_gen.sv
// N-layer colour mixer: priority table, banked palette, 4-stage pixel pipeline, CPU palette port.
module color_mixer_gen
   import color_mixer_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned OBP_W      = 2,
   parameter int unsigned BANK_W     = 1,
   parameter int unsigned CPU_MODE   = 0
) (
   input logic              CLK6,
   input logic              NRESET,
   color_mixer_gen_if.slave bus
);

   localparam int unsigned SEL_W  = sel_w(NUM_LAYERS);
   localparam int unsigned PAL_AW = pal_aw(IDX_W, BANK_W);
   localparam int unsigned TA_W   = OBP_W + NUM_LAYERS;
   localparam int unsigned TE_W   = BANK_W + SEL_W;
   localparam int unsigned TBL_N  = 1 << TA_W;

   logic                        blk1_q, blk2_q, blk3_q, blk4_q;
   logic [NUM_LAYERS-1:0]       lay_n1_q;
   logic [NUM_LAYERS*IDX_W-1:0] idx1_q;
   logic [OBP_W-1:0]            obp1_q;
   logic [PAL_AW-1:0]           paddr2_q;
   logic [CH_W-1:0]             r_q, g_q, b_q;
   logic [TE_W-1:0]             tbl_q [TBL_N];
   logic [7:0]                  dout_q;

   cpu_state_t                  state_q, state_d;
   logic [PAL_AW:0]             badr_q;
   logic [7:0]                  bdat_q;
   logic                        bwr_q;

   logic [TE_W-1:0]             vid_te;
   logic [SEL_W-1:0]            vid_sel;
   logic [BANK_W-1:0]           vid_bank;
   logic [IDX_W-1:0]            vid_idx;

   logic                        cpu_req, pram_wr, pram_rd, slot_free, live, commit, nwait;
   logic [PAL_AW:0]             act_addr;
   logic [7:0]                  act_dat;
   logic                        act_wr;
   logic                        ram_we;
   logic [1:0]                  ram_be;
   logic [PAL_AW-1:0]           ram_addr;
   logic [15:0]                 ram_wdata, ram_rdata;

   // priority lookup and layer select for the pixel sitting in R1
   always_comb begin
      vid_te   = tbl_q[{obp1_q, lay_n1_q}];
      vid_sel  = vid_te[SEL_W-1:0];
      vid_bank = vid_te[TE_W-1:SEL_W];
      vid_idx  = '0;
      for (int unsigned k = 0; k < NUM_LAYERS; k++)
         if (vid_sel == SEL_W'(k)) vid_idx = idx1_q[k*IDX_W +: IDX_W];
   end

   // CPU decode, request FSM next state and palette port arbitration
   always_comb begin
      cpu_req   = bus.CRAMCS & (~bus.NRD | ~bus.NWR);
      pram_wr   = bus.PRAMCS & ~bus.CRAMCS & ~bus.NWR;
      pram_rd   = bus.PRAMCS & ~bus.CRAMCS & ~bus.NRD & bus.NWR;
      slot_free = (CPU_MODE != 0) || !blk2_q;
      // a fresh strobe is served straight from the bus so it can commit on its first edge
      live      = (state_q == CPU_IDLE) & cpu_req;
      act_addr  = live ? bus.ADDR : badr_q;
      act_dat   = live ? bus.DIN : bdat_q;
      act_wr    = live ? ~bus.NWR : bwr_q;
      commit    = NRESET & (live | (state_q == CPU_PEND)) & slot_free;
      nwait     = ~(NRESET & (live | (state_q == CPU_PEND) | (state_q == CPU_RDWT)));
      state_d   = state_q;
      unique case (state_q)
         CPU_IDLE: if (live && NRESET) state_d = commit ? (act_wr ? CPU_DONE : CPU_RDWT) : CPU_PEND;
         CPU_PEND: if (commit) state_d = act_wr ? CPU_DONE : CPU_RDWT;
         CPU_RDWT: state_d = CPU_DONE;
         CPU_DONE: if (!cpu_req) state_d = CPU_IDLE;
         default:  state_d = CPU_IDLE;
      endcase
      ram_we    = commit & act_wr;
      ram_be    = act_addr[0] ? 2'b01 : 2'b10;
      ram_addr  = commit ? act_addr[PAL_AW:1] : paddr2_q;
      ram_wdata = {act_dat, act_dat};
   end

   color_pal_ram #(.AW(PAL_AW)) u_pal (
      .clk_i   (CLK6),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // pixel pipeline: capture, palette address, (RAM read), colour output
   always_ff @(posedge CLK6 or negedge NRESET) begin
      if (!NRESET) begin
         blk1_q   <= 1'b0;
         blk2_q   <= 1'b0;
         blk3_q   <= 1'b0;
         blk4_q   <= 1'b0;
         lay_n1_q <= '0;
         idx1_q   <= '0;
         obp1_q   <= '0;
         paddr2_q <= '0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
      end else begin
         blk1_q   <= bus.NCBLK;
         lay_n1_q <= bus.LAYER_N;
         idx1_q   <= bus.LAYER_IDX;
         obp1_q   <= bus.OBP;
         blk2_q   <= blk1_q;
         paddr2_q <= {vid_bank, vid_idx};
         blk3_q   <= blk2_q;
         blk4_q   <= blk3_q;
         r_q      <= blk3_q ? ram_rdata[R_LSB +: CH_W] : '0;
         g_q      <= blk3_q ? ram_rdata[G_LSB +: CH_W] : '0;
         b_q      <= blk3_q ? ram_rdata[B_LSB +: CH_W] : '0;
      end
   end

   // priority table: default rule on reset, CPU byte writes otherwise
   always_ff @(posedge CLK6 or negedge NRESET) begin
      if (!NRESET) begin
         for (int unsigned a = 0; a < TBL_N; a++)
            tbl_q[a] <= TE_W'(default_sel(a, NUM_LAYERS));
      end else if (pram_wr) begin
         tbl_q[bus.ADDR[TA_W-1:0]] <= bus.DIN[TE_W-1:0];
      end
   end

   // CPU request state, access buffer and read-data register
   always_ff @(posedge CLK6 or negedge NRESET) begin
      if (!NRESET) begin
         state_q <= CPU_IDLE;
         badr_q  <= '0;
         bdat_q  <= '0;
         bwr_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         if (live) begin
            badr_q <= bus.ADDR;
            bdat_q <= bus.DIN;
            bwr_q  <= ~bus.NWR;
         end
         if (state_q == CPU_RDWT)
            dout_q <= badr_q[0] ? ram_rdata[7:0] : ram_rdata[15:8];
         else if (pram_rd)
            dout_q <= 8'(tbl_q[bus.ADDR[TA_W-1:0]]);
      end
   end

   assign bus.R       = r_q;
   assign bus.G       = g_q;
   assign bus.B       = b_q;
   assign bus.BLK_OUT = blk4_q;
   assign bus.NWAIT   = nwait;
   assign bus.DOUT    = dout_q;

endmodule
